x_uart_rx: RTL

//  UART 8N1 receiver. It is the decode path for the host->FPGA link, feeding command bytes
//  (capture trigger, tap/length select) to the delay-line control logic. It replaces the

---
 rtl/uart_pkg.sv | 8 +
 rtl/x_uart_rx_if.sv | 8 +
 rtl/x_uart_bit_timer.sv | 22 ++
 rtl/x_uart_rx.sv | 87 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type, frame width and bit-timer sizing helper.
package uart_pkg;
   typedef enum logic [3:0] {IDLE, START, D0, D1, D2, D3, D4, D5, D6, D7, PAR, STOP} uart_rx_sm_t;
   localparam int p_uart_length = 8;
   function automatic int uart_timer_top(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
endpackage

// File: rtl/x_uart_rx_if.sv
// x_uart_rx_if: received-byte valid/ready handshake plus error and status strobes.
interface x_uart_rx_if;
   import uart_pkg::*;
   logic [p_uart_length-1:0] o_data;
   logic o_valid, i_ready, o_frame_err, o_overrun, o_parity_err, o_busy;
   modport master (output o_data, o_valid, o_frame_err, o_overrun, o_parity_err, o_busy, input i_ready);
   modport slave (input o_data, o_valid, o_frame_err, o_overrun, o_parity_err, o_busy, output i_ready);
endinterface

// File: rtl/x_uart_bit_timer.sv
// x_uart_bit_timer: bit-period counter 0..p_top-1 with end-of-period and mid-period strobes.
module x_uart_bit_timer #(
   parameter int p_top = 10
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clr,
   input  logic en,
   output logic tick,
   output logic half
);
   localparam int w = p_top > 1 ? $clog2(p_top) : 1;
   localparam logic [w-1:0] c_top = w'(p_top - 1);
   localparam logic [w-1:0] c_half = w'(p_top / 2 - 1);
   logic [w-1:0] cnt;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + 1'b1;
   assign tick = cnt == c_top;
   assign half = cnt == c_half;
endmodule

// File: rtl/x_uart_rx.sv
// x_uart_rx: 8N1 UART receiver with a one-entry holding register and error strobes.
// Define UART_RX_PARITY_EN to insert an even-parity bit check between D7 and STOP.
module x_uart_rx
   import uart_pkg::*;
#(
   parameter int p_clk_hz = 79500000,
   parameter int p_baud   = 115200
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_uart_rx,
   x_uart_rx_if.master bus
);
   localparam int p_timer_top = uart_timer_top(p_clk_hz, p_baud);
`ifdef UART_RX_PARITY_EN
   localparam uart_rx_sm_t after_d7 = PAR;
   logic par_bad;
`else
   localparam uart_rx_sm_t after_d7 = STOP;
   localparam logic par_bad = 1'b0;
   assign bus.o_parity_err = 1'b0;
`endif
   uart_rx_sm_t state;
   logic p1, p2, tick, half, start, clr;
   logic [p_uart_length-1:0] sr;
   assign start = state == IDLE && !p1 && p2;
   // restarting the timer at mid start bit puts every later tick mid-bit
   assign clr = start || (state == START && half && !p1);
   assign bus.o_busy = state != IDLE;
   x_uart_bit_timer #(.p_top(p_timer_top)) u_timer (
      .i_clk, .i_rst, .clr, .en(bus.o_busy), .tick, .half
   );
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         p1 <= 1'b1;
         p2 <= 1'b1;
         state <= IDLE;
         sr <= '0;
         bus.o_data <= '0;
         bus.o_valid <= 1'b0;
         bus.o_frame_err <= 1'b0;
         bus.o_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.o_parity_err <= 1'b0;
         par_bad <= 1'b0;
`endif
      end else begin
         p1 <= i_uart_rx;
         p2 <= p1;
         bus.o_frame_err <= 1'b0;
         bus.o_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.o_parity_err <= 1'b0;
`endif
         if (bus.o_valid && bus.i_ready) bus.o_valid <= 1'b0;
         case (state)
            IDLE: if (start) state <= START;
            START: if (half) state <= p1 ? IDLE : D0;
            D0, D1, D2, D3, D4, D5, D6, D7:
               if (tick) begin
                  sr <= {p1, sr[p_uart_length-1:1]};
                  state <= state == D7 ? after_d7 : uart_rx_sm_t'(state + 4'd1);
               end
`ifdef UART_RX_PARITY_EN
            PAR:
               if (tick) begin
                  par_bad <= p1 != ^sr;
                  bus.o_parity_err <= p1 != ^sr;
                  state <= STOP;
               end
`endif
            STOP:
               if (tick) begin
                  state <= IDLE;
                  if (!p1) bus.o_frame_err <= 1'b1;
                  else if (!par_bad) begin
                     if (bus.o_valid && !bus.i_ready) bus.o_overrun <= 1'b1;
                     else begin
                        bus.o_data <= sr;
                        bus.o_valid <= 1'b1;
                     end
                  end
               end
            default: state <= IDLE;
         endcase
      end
endmodule
